// File: rtl/versatile_mem_ctrl_pkg.sv
// Shared types and helpers for the Wishbone front-end arbiter of the memory controller.
// Holds the bridge FSM encoding, Wishbone cycle/burst type codes and the burst-length decode.
package versatile_mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2,
        ST_FE   = 2'd3
    } arb_state_t;

    localparam logic [2:0] CTI_INCR   = 3'b010;
    localparam logic [2:0] CTI_EOB    = 3'b111;
    localparam logic [1:0] BTE_WRAP4  = 2'b01;
    localparam logic [1:0] BTE_WRAP8  = 2'b10;
    localparam logic [1:0] BTE_WRAP16 = 2'b11;

    // Only incrementing wrap bursts have a known length; everything else is one beat.
    function automatic logic [4:0] burst_len(input logic [2:0] cti, input logic [1:0] bte);
        logic [4:0] len;
        len = 5'd1;
        if (cti == CTI_INCR) begin
            case (bte)
                BTE_WRAP4:  len = 5'd4;
                BTE_WRAP8:  len = 5'd8;
                BTE_WRAP16: len = 5'd16;
                default:    len = 5'd1;
            endcase
        end else begin
            len = 5'd1;
        end
        return len;
    endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester after the last accepted winner.
// The pointer advances only when the caller signals acceptance through en.
module wb_rr_arbiter
    import versatile_mem_ctrl_pkg::*;
#(
    parameter int NR_OF_PORTS = 2
) (
    input  logic                   wb_clk,
    input  logic                   wb_rst,
    input  logic [NR_OF_PORTS-1:0] req,
    input  logic                   en,
    output logic [NR_OF_PORTS-1:0] gnt
);

    localparam int IDX_W = (NR_OF_PORTS > 1) ? $clog2(NR_OF_PORTS) : 1;

    logic [IDX_W-1:0] last_r;
    logic [IDX_W-1:0] win_idx_s;

    // Search requesters starting one past the last owner, wrapping around.
    always_comb begin
        int               idx;
        logic             found;
        logic             hit;
        logic [IDX_W-1:0] sel;
        gnt       = '0;
        win_idx_s = last_r;
        found     = 1'b0;
        idx       = 0;
        hit       = 1'b0;
        sel       = '0;
        for (int i = 1; i <= NR_OF_PORTS; i++) begin
            idx       = int'(last_r) + i;
            idx       = (idx >= NR_OF_PORTS) ? (idx - NR_OF_PORTS) : idx;
            sel       = IDX_W'(idx);
            hit       = !found && req[sel];
            gnt[sel]  = gnt[sel] | hit;
            win_idx_s = hit ? sel : win_idx_s;
            found     = found | hit;
        end
    end

    // Reset points at the highest port so port 0 is served first.
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            last_r <= IDX_W'(NR_OF_PORTS - 1);
        end else if (en) begin
            last_r <= win_idx_s;
        end else begin
            last_r <= last_r;
        end
    end

endmodule

// File: rtl/fsm_wb_arb.sv
// Wishbone multi-port front end: arbitrates slave ports onto the egress command/write FIFO
// and returns read data from the ingress FIFO, tracking burst length per grant.
module fsm_wb_arb
    import versatile_mem_ctrl_pkg::*;
#(
    parameter int NR_OF_PORTS = 2,
    parameter int CNT_W       = 5
) (
    input  logic                     wb_clk,
    input  logic                     wb_rst,
    input  logic [NR_OF_PORTS-1:0]   cyc_i,
    input  logic [NR_OF_PORTS-1:0]   stb_i,
    input  logic [NR_OF_PORTS-1:0]   we_i,
    input  logic [3*NR_OF_PORTS-1:0] cti_i,
    input  logic [2*NR_OF_PORTS-1:0] bte_i,
    output logic [NR_OF_PORTS-1:0]   ack_o,
    output logic [NR_OF_PORTS-1:0]   stall_o,
    input  logic                     stall_i,
    output logic                     egress_fifo_we,
    input  logic                     egress_fifo_full,
    output logic                     ingress_fifo_re,
    input  logic                     ingress_fifo_empty,
    output logic [NR_OF_PORTS-1:0]   grant_o
);

    localparam int N = NR_OF_PORTS;

    arb_state_t       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [N-1:0]     owner_r;
    logic [N-1:0]     rd_ack_r;

    logic [N-1:0]     req_s, win_s, sel_s, wr_ack_s, stall_s;
    logic [2:0]       win_cti_s, own_cti_s;
    logic [1:0]       win_bte_s;
    logic [CNT_W-1:0] len_s;
    logic             win_we_s, own_req_s, own_cyc_s, rd_pend_s, last_beat_s;
    logic             accept_s, wr_beat_s, rd_beat_s, fe_beat_s, beat_acc_s;

    assign req_s = cyc_i & stb_i;

    wb_rr_arbiter #(
        .NR_OF_PORTS(N)
    ) u_arb (
        .wb_clk (wb_clk),
        .wb_rst (wb_rst),
        .req    (req_s),
        .en     (accept_s),
        .gnt    (win_s)
    );

    // One-hot AND-OR muxes pick the winner's and owner's cycle attributes.
    always_comb begin
        win_cti_s = 3'b000;
        win_bte_s = 2'b00;
        own_cti_s = 3'b000;
        for (int p = 0; p < N; p++) begin
            win_cti_s = win_cti_s | (cti_i[3*p +: 3] & {3{win_s[p]}});
            win_bte_s = win_bte_s | (bte_i[2*p +: 2] & {2{win_s[p]}});
            own_cti_s = own_cti_s | (cti_i[3*p +: 3] & {3{owner_r[p]}});
        end
    end

    assign win_we_s    = |(win_s & we_i);
    assign own_req_s   = |(owner_r & req_s);
    assign own_cyc_s   = |(owner_r & cyc_i);
    assign rd_pend_s   = |rd_ack_r;
    assign len_s       = CNT_W'(burst_len(win_cti_s, win_bte_s));
    assign last_beat_s = (cnt_r == CNT_W'(1)) || (own_cti_s == CTI_EOB);

    // A write entry would ack alongside the trailing read ack, so it waits one cycle.
    always_comb begin
        accept_s   = (state_r == ST_IDLE) && (|req_s) && !egress_fifo_full && !stall_i
                     && !(win_we_s && rd_pend_s);
        wr_beat_s  = (state_r == ST_WR) && own_req_s && !egress_fifo_full && !stall_i;
        rd_beat_s  = (state_r == ST_RD) && own_req_s && !ingress_fifo_empty && !stall_i;
        fe_beat_s  = (state_r == ST_FE) && !ingress_fifo_empty && (cnt_r != '0);
        beat_acc_s = accept_s | wr_beat_s | rd_beat_s;
        sel_s      = (state_r == ST_IDLE) ? win_s : owner_r;
        wr_ack_s   = (accept_s && win_we_s) ? win_s : (wr_beat_s ? owner_r : '0);
        stall_s    = {N{stall_i}} | (req_s & ~(sel_s & {N{beat_acc_s}}));
    end

    // Bridge FSM: ownership, remaining beats and the one-cycle-late read ack.
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state_r  <= ST_IDLE;
            cnt_r    <= '0;
            owner_r  <= '0;
            rd_ack_r <= '0;
        end else begin
            rd_ack_r <= rd_beat_s ? owner_r : '0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s && win_we_s && (len_s != CNT_W'(1))) begin
                        state_r <= ST_WR;
                        cnt_r   <= len_s - CNT_W'(1);
                        owner_r <= win_s;
                    end else if (accept_s && !win_we_s) begin
                        state_r <= ST_RD;
                        cnt_r   <= len_s;
                        owner_r <= win_s;
                    end
                end
                ST_WR: begin
                    if (!own_cyc_s) begin
                        state_r <= ST_IDLE;
                        owner_r <= '0;
                    end else if (wr_beat_s) begin
                        cnt_r <= cnt_r - CNT_W'(1);
                        if (last_beat_s) begin
                            state_r <= ST_IDLE;
                            owner_r <= '0;
                        end
                    end
                end
                ST_RD: begin
                    if (!own_cyc_s) begin
                        state_r <= ST_FE;
                    end else if (rd_beat_s) begin
                        cnt_r <= cnt_r - CNT_W'(1);
                        if (last_beat_s) begin
                            state_r <= ST_IDLE;
                            owner_r <= '0;
                        end
                    end
                end
                ST_FE: begin
                    if (cnt_r == '0) begin
                        state_r <= ST_IDLE;
                        owner_r <= '0;
                    end else if (fe_beat_s) begin
                        cnt_r <= cnt_r - CNT_W'(1);
                        if (cnt_r == CNT_W'(1)) begin
                            state_r <= ST_IDLE;
                            owner_r <= '0;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    owner_r <= '0;
                end
            endcase
        end
    end

    // Input-dependent strobes are forced low while reset is held.
    assign ack_o           = wb_rst ? '0 : (wr_ack_s | rd_ack_r);
    assign stall_o         = wb_rst ? '0 : stall_s;
    assign egress_fifo_we  = wb_rst ? 1'b0 : (accept_s | wr_beat_s);
    assign ingress_fifo_re = wb_rst ? 1'b0 : (rd_beat_s | fe_beat_s);
    assign grant_o         = owner_r;

endmodule

// File: tb/tb_fsm_wb_arb.sv
// Vector-table bench for fsm_wb_arb: each cycle's inputs and expected outputs are queued
// when driven and compared on the falling edge.
module tb_fsm_wb_arb;

    logic       wb_clk = 1'b0;
    logic       wb_rst;
    logic [1:0] cyc_i, stb_i, we_i;
    logic [5:0] cti_i;
    logic [3:0] bte_i;
    logic [1:0] ack_o, stall_o, grant_o;
    logic       stall_i, egress_fifo_we, egress_fifo_full, ingress_fifo_re, ingress_fifo_empty;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        logic [1:0] req;
        logic [1:0] we;
        logic [5:0] cti;
        logic [3:0] bte;
        logic       full;
        logic       empty;
        logic       stl;
        logic [1:0] ack;
        logic [1:0] stall;
        logic       ewe;
        logic       ire;
        logic [1:0] gnt;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    fsm_wb_arb #(
        .NR_OF_PORTS(2),
        .CNT_W(5)
    ) dut (
        .wb_clk             (wb_clk),
        .wb_rst             (wb_rst),
        .cyc_i              (cyc_i),
        .stb_i              (stb_i),
        .we_i               (we_i),
        .cti_i              (cti_i),
        .bte_i              (bte_i),
        .ack_o              (ack_o),
        .stall_o            (stall_o),
        .stall_i            (stall_i),
        .egress_fifo_we     (egress_fifo_we),
        .egress_fifo_full   (egress_fifo_full),
        .ingress_fifo_re    (ingress_fifo_re),
        .ingress_fifo_empty (ingress_fifo_empty),
        .grant_o            (grant_o)
    );

    always #5 wb_clk = ~wb_clk;

    function automatic vec_t mk(input string name, input logic [1:0] req, input logic [1:0] we,
                                input logic [5:0] cti, input logic [3:0] bte, input logic full,
                                input logic empty, input logic stl, input logic [1:0] ack,
                                input logic [1:0] stall, input logic ewe, input logic ire,
                                input logic [1:0] gnt);
        vec_t v;
        v.name = name; v.req = req; v.we = we; v.cti = cti; v.bte = bte;
        v.full = full; v.empty = empty; v.stl = stl;
        v.ack = ack; v.stall = stall; v.ewe = ewe; v.ire = ire; v.gnt = gnt;
        return v;
    endfunction

    task automatic chk(input string name, input string fld, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s %s got=%0h expected=%0h", name, fld, got, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        @(posedge wb_clk);
        #1;
        cyc_i              = v.req;
        stb_i              = v.req;
        we_i               = v.we;
        cti_i              = v.cti;
        bte_i              = v.bte;
        egress_fifo_full   = v.full;
        ingress_fifo_empty = v.empty;
        stall_i            = v.stl;
        sb.push_back(v);
    endtask

    // Scoreboard: compare the oldest queued expectation mid-cycle.
    always @(negedge wb_clk) begin : mon
        vec_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.name, "ack_o", {6'd0, ack_o}, {6'd0, e.ack});
            chk(e.name, "stall_o", {6'd0, stall_o}, {6'd0, e.stall});
            chk(e.name, "egress_fifo_we", {7'd0, egress_fifo_we}, {7'd0, e.ewe});
            chk(e.name, "ingress_fifo_re", {7'd0, ingress_fifo_re}, {7'd0, e.ire});
            chk(e.name, "grant_o", {6'd0, grant_o}, {6'd0, e.gnt});
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with busy inputs: every output must read zero.
        wb_rst = 1'b1;
        cyc_i = 2'b11; stb_i = 2'b11; we_i = 2'b11; cti_i = 6'd0; bte_i = 4'd0;
        stall_i = 1'b1; egress_fifo_full = 1'b0; ingress_fifo_empty = 1'b0;
        #3;
        chk("reset", "ack_o", {6'd0, ack_o}, 8'd0);
        chk("reset", "stall_o", {6'd0, stall_o}, 8'd0);
        chk("reset", "egress_fifo_we", {7'd0, egress_fifo_we}, 8'd0);
        chk("reset", "ingress_fifo_re", {7'd0, ingress_fifo_re}, 8'd0);
        chk("reset", "grant_o", {6'd0, grant_o}, 8'd0);
        @(posedge wb_clk);
        #1;
        wb_rst = 1'b0;

        // name, req, we, cti, bte, full, empty, stall_i | ack, stall_o, egress_we, ingress_re, grant
        tbl.push_back(mk("rr0", 2'b11, 2'b11, 6'o00, 4'h0, 1'b0, 1'b1, 1'b0, 2'b01, 2'b10, 1'b1, 1'b0, 2'b00));
        tbl.push_back(mk("rr1", 2'b11, 2'b11, 6'o00, 4'h0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b01, 1'b1, 1'b0, 2'b00));
        tbl.push_back(mk("rr2", 2'b11, 2'b11, 6'o00, 4'h0, 1'b0, 1'b1, 1'b0, 2'b01, 2'b10, 1'b1, 1'b0, 2'b00));
        tbl.push_back(mk("rr3", 2'b11, 2'b11, 6'o00, 4'h0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b01, 1'b1, 1'b0, 2'b00));
        tbl.push_back(mk("single_wr", 2'b01, 2'b01, 6'o00, 4'h0, 1'b0, 1'b1, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 2'b00));
        tbl.push_back(mk("idle", 2'b00, 2'b00, 6'o00, 4'h0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00));
        // port 1 wrap8 read
        tbl.push_back(mk("rd8_cmd", 2'b10, 2'b00, 6'o20, 4'h8, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00));
        tbl.push_back(mk("rd8_b1", 2'b10, 2'b00, 6'o20, 4'h8, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 2'b10));
        for (int b = 2; b <= 8; b++)
            tbl.push_back(mk($sformatf("rd8_b%0d", b), 2'b10, 2'b00, 6'o20, 4'h8, 1'b0, 1'b0, 1'b0,
                             2'b10, 2'b00, 1'b0, 1'b1, 2'b10));
        tbl.push_back(mk("rd8_lastack", 2'b01, 2'b01, 6'o00, 4'h0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 1'b0, 1'b0, 2'b00));
        tbl.push_back(mk("after_rd_wr", 2'b01, 2'b01, 6'o00, 4'h0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 2'b00));
        // port 0 wrap4 read, cyc dropped after one beat
        tbl.push_back(mk("fe_cmd", 2'b01, 2'b00, 6'o02, 4'h1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00));
        tbl.push_back(mk("fe_b1", 2'b01, 2'b00, 6'o02, 4'h1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 2'b01));
        tbl.push_back(mk("fe_drop", 2'b00, 2'b00, 6'o02, 4'h1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 2'b01));
        tbl.push_back(mk("fe_f1", 2'b00, 2'b00, 6'o02, 4'h1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 2'b01));
        tbl.push_back(mk("fe_empty", 2'b00, 2'b00, 6'o02, 4'h1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b01));
        tbl.push_back(mk("fe_f2", 2'b00, 2'b00, 6'o02, 4'h1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 2'b01));
        tbl.push_back(mk("fe_f3", 2'b00, 2'b00, 6'o02, 4'h1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 2'b01));
        tbl.push_back(mk("fe_idle", 2'b00, 2'b00, 6'o00, 4'h0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00));
        // port 1 wrap4 write against a full egress FIFO and downstream stall
        tbl.push_back(mk("wr4_full", 2'b10, 2'b10, 6'o20, 4'h4, 1'b1, 1'b1, 1'b0, 2'b00, 2'b10, 1'b0, 1'b0, 2'b00));
        tbl.push_back(mk("wr4_b1", 2'b10, 2'b10, 6'o20, 4'h4, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 1'b1, 1'b0, 2'b00));
        tbl.push_back(mk("wr4_full2", 2'b10, 2'b10, 6'o20, 4'h4, 1'b1, 1'b1, 1'b0, 2'b00, 2'b10, 1'b0, 1'b0, 2'b10));
        tbl.push_back(mk("wr4_b2", 2'b10, 2'b10, 6'o20, 4'h4, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 1'b1, 1'b0, 2'b10));
        tbl.push_back(mk("wr4_b3_contend", 2'b11, 2'b10, 6'o20, 4'h4, 1'b0, 1'b1, 1'b0, 2'b10, 2'b01, 1'b1, 1'b0, 2'b10));
        tbl.push_back(mk("wr4_stall_i", 2'b10, 2'b10, 6'o20, 4'h4, 1'b0, 1'b1, 1'b1, 2'b00, 2'b11, 1'b0, 1'b0, 2'b10));
        tbl.push_back(mk("wr4_b4", 2'b10, 2'b10, 6'o20, 4'h4, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 1'b1, 1'b0, 2'b10));
        tbl.push_back(mk("wr4_idle", 2'b00, 2'b00, 6'o00, 4'h0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00));
        // port 0 wrap8 write cut short by end-of-burst cti
        tbl.push_back(mk("eob_b1", 2'b01, 2'b01, 6'o02, 4'h2, 1'b0, 1'b1, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 2'b00));
        tbl.push_back(mk("eob_b2", 2'b01, 2'b01, 6'o07, 4'h2, 1'b0, 1'b1, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 2'b01));
        tbl.push_back(mk("eob_idle", 2'b00, 2'b00, 6'o00, 4'h0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // port 0 wrap16 read, reset asserted mid-burst
        apply(mk("rd16_cmd", 2'b01, 2'b00, 6'o02, 4'h3, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00));
        apply(mk("rd16_b1", 2'b01, 2'b00, 6'o02, 4'h3, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 2'b01));
        apply(mk("rd16_b2", 2'b01, 2'b00, 6'o02, 4'h3, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b1, 2'b01));
        apply(mk("rd16_b3", 2'b01, 2'b00, 6'o02, 4'h3, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b1, 2'b01));
        @(posedge wb_clk);
        #1;
        stall_i = 1'b1;
        #2;
        wb_rst = 1'b1;
        #1;
        chk("midrst", "ack_o", {6'd0, ack_o}, 8'd0);
        chk("midrst", "stall_o", {6'd0, stall_o}, 8'd0);
        chk("midrst", "egress_fifo_we", {7'd0, egress_fifo_we}, 8'd0);
        chk("midrst", "ingress_fifo_re", {7'd0, ingress_fifo_re}, 8'd0);
        chk("midrst", "grant_o", {6'd0, grant_o}, 8'd0);
        @(posedge wb_clk);
        #1;
        wb_rst = 1'b0;
        apply(mk("post_rst_p0", 2'b11, 2'b11, 6'o00, 4'h0, 1'b0, 1'b1, 1'b0, 2'b01, 2'b10, 1'b1, 1'b0, 2'b00));
        apply(mk("post_rst_idle", 2'b00, 2'b00, 6'o00, 4'h0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00));

        @(negedge wb_clk);
        #1;
        chk("sb_drain", "queued", 8'(sb.size()), 8'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
